// File: rtl/cache_types_pkg.sv
// Shared types for the cache controller: FSM states and datapath write-source codes.
package cache_types_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        CHECK     = 2'b01,
        WRITEBACK = 2'b10,
        FILL      = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        WR_FILL = 2'b00,
        WR_CPU  = 2'b01,
        WR_NONE = 2'b10
    } writing_t;

endpackage

// File: rtl/lru_rank_table.sv
// Per-set true-LRU rank registers; rank 0 is most recent, rank NUM_WAYS-1 is the LRU way.
module lru_rank_table
    import cache_types_pkg::*;
#(
    parameter int unsigned NUM_WAYS   = 2,
    parameter int unsigned WAYS_LOG_2 = $clog2(NUM_WAYS),
    parameter int unsigned NUM_SETS   = 8,
    parameter int unsigned SET_BITS   = $clog2(NUM_SETS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SET_BITS-1:0]   rd_set,
    output logic [WAYS_LOG_2-1:0] lru_way,
    input  logic                  upd_en,
    input  logic [SET_BITS-1:0]   upd_set,
    input  logic [WAYS_LOG_2-1:0] upd_way
);

    logic [WAYS_LOG_2-1:0] rank_q [NUM_SETS][NUM_WAYS];
    logic [WAYS_LOG_2-1:0] rank_d [NUM_SETS][NUM_WAYS];
    logic [WAYS_LOG_2-1:0] hit_rank;

    // Promote the touched way to rank 0 and age only the ways that were more recent than it.
    always_comb begin
        rank_d   = rank_q;
        hit_rank = rank_q[upd_set][upd_way];
        if (upd_en) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (WAYS_LOG_2'(w) == upd_way) begin
                    rank_d[upd_set][w] = '0;
                end else if (rank_q[upd_set][w] < hit_rank) begin
                    rank_d[upd_set][w] = rank_q[upd_set][w] + WAYS_LOG_2'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    rank_q[s][w] <= WAYS_LOG_2'(w);
                end
            end
        end else begin
            rank_q <= rank_d;
        end
    end

    always_comb begin
        lru_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (rank_q[rd_set][w] == WAYS_LOG_2'(NUM_WAYS - 1)) begin
                lru_way = WAYS_LOG_2'(w);
            end
        end
    end

endmodule

// File: rtl/cache_control.sv
// Cache controller FSM: hit check, dirty-victim writeback and line fill for an N-way cache.
module cache_control
    import cache_types_pkg::*;
#(
    parameter int unsigned NUM_WAYS   = 2,
    parameter int unsigned WAYS_LOG_2 = $clog2(NUM_WAYS),
    parameter int unsigned NUM_SETS   = 8,
    parameter int unsigned SET_BITS   = $clog2(NUM_SETS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  mem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    input  logic                  pmem_resp,
    input  logic [SET_BITS-1:0]   set_index,
    input  logic                  hit,
    input  logic [WAYS_LOG_2-1:0] hit_way,
    input  logic [NUM_WAYS-1:0]   valid_vec,
    input  logic [NUM_WAYS-1:0]   dirty_vec,
    output logic [WAYS_LOG_2-1:0] way_sel,
    output logic [NUM_WAYS-1:0]   tag_load,
    output logic [NUM_WAYS-1:0]   valid_load,
    output logic [NUM_WAYS-1:0]   dirty_load,
    output logic                  dirty_in,
    output logic [1:0]            writing,
    output logic                  addr_sel
);

    state_t                state_q, state_d;
    logic [WAYS_LOG_2-1:0] victim_q, victim_d;
    logic [WAYS_LOG_2-1:0] lru_way;
    logic [WAYS_LOG_2-1:0] miss_victim;
    logic                  found_invalid;
    logic                  lru_upd_en;
    logic [NUM_WAYS-1:0]   hit_oh;
    logic [NUM_WAYS-1:0]   victim_oh;

    lru_rank_table #(
        .NUM_WAYS  (NUM_WAYS),
        .WAYS_LOG_2(WAYS_LOG_2),
        .NUM_SETS  (NUM_SETS),
        .SET_BITS  (SET_BITS)
    ) u_lru (
        .clk    (clk),
        .rst    (rst),
        .rd_set (set_index),
        .lru_way(lru_way),
        .upd_en (lru_upd_en),
        .upd_set(set_index),
        .upd_way(hit_way)
    );

    assign hit_oh    = NUM_WAYS'(1) << hit_way;
    assign victim_oh = NUM_WAYS'(1) << victim_q;

    // An empty way always wins over evicting the LRU line.
    always_comb begin
        miss_victim   = lru_way;
        found_invalid = 1'b0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!found_invalid && !valid_vec[w]) begin
                miss_victim   = WAYS_LOG_2'(w);
                found_invalid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        lru_upd_en = 1'b0;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        way_sel    = '0;
        tag_load   = '0;
        valid_load = '0;
        dirty_load = '0;
        dirty_in   = 1'b0;
        writing    = WR_NONE;
        addr_sel   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (hit) begin
                    way_sel    = hit_way;
                    mem_resp   = 1'b1;
                    lru_upd_en = 1'b1;
                    // A simultaneous read and write request is served as a write.
                    if (mem_write) begin
                        writing    = WR_CPU;
                        dirty_load = hit_oh;
                        dirty_in   = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    victim_d = miss_victim;
                    if (valid_vec[miss_victim] && dirty_vec[miss_victim]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            WRITEBACK: begin
                way_sel    = victim_q;
                addr_sel   = 1'b1;
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    state_d = FILL;
                end
            end

            FILL: begin
                way_sel   = victim_q;
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    writing    = WR_FILL;
                    tag_load   = victim_oh;
                    valid_load = victim_oh;
                    dirty_load = victim_oh;
                    state_d    = CHECK;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_control.sv
// Scenario bench for cache_control: the bench plays the datapath and physical memory.
module tb_cache_control;

    localparam int unsigned NW = 2;
    localparam int unsigned WL = 1;
    localparam int unsigned NS = 8;
    localparam int unsigned SB = 3;
    localparam int unsigned OW = 4 + WL + 3 * NW + 1 + 2;
    localparam logic [OW-1:0] IDLE_OUTS = OW'(2'b10);

    logic          clk, rst;
    logic          mem_read, mem_write, mem_resp;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [SB-1:0] set_index;
    logic          hit;
    logic [WL-1:0] hit_way;
    logic [NW-1:0] valid_vec, dirty_vec;
    logic [WL-1:0] way_sel;
    logic [NW-1:0] tag_load, valid_load, dirty_load;
    logic          dirty_in;
    logic [1:0]    writing;
    logic          addr_sel;

    typedef struct {
        int            req_cyc;
        int            lat;
        logic [1:0]    wr;
        logic [NW-1:0] dload;
        logic          din;
        logic [WL-1:0] way;
    } resp_t;

    resp_t sb_q[$];
    int    total;
    int    bad;
    int    cyc;

    cache_control #(
        .NUM_WAYS(NW), .WAYS_LOG_2(WL), .NUM_SETS(NS), .SET_BITS(SB)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .set_index(set_index), .hit(hit), .hit_way(hit_way),
        .valid_vec(valid_vec), .dirty_vec(dirty_vec),
        .way_sel(way_sel), .tag_load(tag_load), .valid_load(valid_load),
        .dirty_load(dirty_load), .dirty_in(dirty_in), .writing(writing),
        .addr_sel(addr_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] outs();
        return {mem_resp, pmem_read, pmem_write, addr_sel, way_sel,
                tag_load, valid_load, dirty_load, dirty_in, writing};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_read = 1'b1; mem_write = 1'b0; pmem_resp = 1'b1;
        set_index = '0; hit = 1'b1; hit_way = '0; valid_vec = '1; dirty_vec = '1;
        repeat (2) @(negedge clk);
        total++;
        if (outs() !== IDLE_OUTS) begin
            bad++; $display("FAIL reset_outs: got %b want %b", outs(), IDLE_OUTS);
        end
        for (int s = 0; s < NS; s++) begin
            total++;
            if ({dut.u_lru.rank_q[s][1], dut.u_lru.rank_q[s][0]} !== 2'b10) begin
                bad++; $display("FAIL reset_rank set %0d: got %b want 10", s,
                                {dut.u_lru.rank_q[s][1], dut.u_lru.rank_q[s][0]});
            end
        end
        tick();
        mem_read = 1'b0; hit = 1'b0; pmem_resp = 1'b0; valid_vec = '0; dirty_vec = '0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic do_hit(input logic [SB-1:0] s, input logic [WL-1:0] w,
                          input logic rd, input logic wr, input string name);
        resp_t         e;
        logic [NW-1:0] oh;
        oh = NW'(1) << w;
        mem_read = rd; mem_write = wr; set_index = s; hit = 1'b1; hit_way = w;
        valid_vec = '1; dirty_vec = '0; pmem_resp = 1'b0;
        e.req_cyc = cyc; e.lat = 2; e.wr = wr ? 2'b01 : 2'b10;
        e.dload = wr ? oh : NW'(0); e.din = wr; e.way = w;
        sb_q.push_back(e);
        @(negedge clk);
        total++;
        if (mem_resp !== 1'b0 || writing !== 2'b10 || dirty_load !== NW'(0)) begin
            bad++; $display("FAIL %s idle: resp=%b writing=%b dload=%b want 0/10/00",
                            name, mem_resp, writing, dirty_load);
        end
        tick();
        @(negedge clk);
        total++;
        if (mem_resp !== 1'b1 || sb_q.size() == 0) begin
            bad++; $display("FAIL %s resp: mem_resp=%b want 1 (queued=%0d)", name, mem_resp, sb_q.size());
        end else begin
            e = sb_q.pop_front();
            total++;
            if ({cyc - e.req_cyc + 1 == e.lat, writing, dirty_load, dirty_in, way_sel} !==
                {1'b1, e.wr, e.dload, e.din, e.way}) begin
                bad++; $display("FAIL %s data: lat=%0d wr=%b dl=%b di=%b way=%b want lat=%0d wr=%b dl=%b di=%b way=%b",
                                name, cyc - e.req_cyc + 1, writing, dirty_load, dirty_in, way_sel,
                                e.lat, e.wr, e.dload, e.din, e.way);
            end
        end
        tick();
        mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0;
    endtask

    task automatic run_miss(input logic [SB-1:0] s, input logic [NW-1:0] vv, input logic [NW-1:0] dv,
                            input logic [WL-1:0] vic, input logic wb, input int wb_n, input int fill_n,
                            input logic wr, input string name);
        resp_t         e;
        logic [NW-1:0] oh;
        logic          last;
        int            pw_rise, pr_rise;
        logic          pw_prev, pr_prev;
        oh = NW'(1) << vic;
        pw_rise = 0; pr_rise = 0; pw_prev = 1'b0; pr_prev = 1'b0;
        mem_read = !wr; mem_write = wr; set_index = s; hit = 1'b0; hit_way = '0;
        valid_vec = vv; dirty_vec = dv; pmem_resp = 1'b0;
        e.req_cyc = cyc; e.lat = 3 + (wb ? wb_n : 0) + fill_n; e.wr = wr ? 2'b01 : 2'b10;
        e.dload = wr ? oh : NW'(0); e.din = wr; e.way = vic;
        sb_q.push_back(e);
        @(negedge clk);
        total++;
        if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
            bad++; $display("FAIL %s idle: resp/pr/pw=%b want 000", name, {mem_resp, pmem_read, pmem_write});
        end
        tick();
        @(negedge clk);
        total++;
        if ({mem_resp, pmem_read, pmem_write, writing} !== 5'b00010) begin
            bad++; $display("FAIL %s check_miss: got %b want 00010", name,
                            {mem_resp, pmem_read, pmem_write, writing});
        end
        tick();
        if (wb) begin
            for (int i = 0; i < wb_n; i++) begin
                pmem_resp = (i == wb_n - 1);
                @(negedge clk);
                if (pmem_write && !pw_prev) pw_rise++;
                if (pmem_read && !pr_prev) pr_rise++;
                pw_prev = pmem_write; pr_prev = pmem_read;
                total++;
                if ({pmem_write, pmem_read, addr_sel, way_sel, writing, tag_load | valid_load | dirty_load,
                     mem_resp} !== {1'b1, 1'b0, 1'b1, vic, 2'b10, NW'(0), 1'b0}) begin
                    bad++; $display("FAIL %s wb[%0d]: pw=%b pr=%b as=%b way=%b wr=%b want 1/0/1/%b/10",
                                    name, i, pmem_write, pmem_read, addr_sel, way_sel, writing, vic);
                end
                tick();
            end
        end
        for (int i = 0; i < fill_n; i++) begin
            last = (i == fill_n - 1);
            pmem_resp = last;
            @(negedge clk);
            if (pmem_write && !pw_prev) pw_rise++;
            if (pmem_read && !pr_prev) pr_rise++;
            pw_prev = pmem_write; pr_prev = pmem_read;
            total++;
            if ({pmem_write, pmem_read, addr_sel, way_sel, writing, tag_load, valid_load, dirty_load, dirty_in} !==
                {1'b0, 1'b1, 1'b0, vic, last ? 2'b00 : 2'b10, last ? oh : NW'(0), last ? oh : NW'(0),
                 last ? oh : NW'(0), 1'b0}) begin
                bad++; $display("FAIL %s fill[%0d]: pw=%b pr=%b as=%b way=%b wr=%b tl=%b vl=%b dl=%b di=%b want way=%b",
                                name, i, pmem_write, pmem_read, addr_sel, way_sel, writing,
                                tag_load, valid_load, dirty_load, dirty_in, vic);
            end
            tick();
        end
        pmem_resp = 1'b0; hit = 1'b1; hit_way = vic; valid_vec = vv | oh; dirty_vec = dv & ~oh;
        @(negedge clk);
        if (pmem_write && !pw_prev) pw_rise++;
        if (pmem_read && !pr_prev) pr_rise++;
        total++;
        if (mem_resp !== 1'b1 || sb_q.size() == 0) begin
            bad++; $display("FAIL %s resp: mem_resp=%b want 1 (queued=%0d)", name, mem_resp, sb_q.size());
        end else begin
            e = sb_q.pop_front();
            total++;
            if ({cyc - e.req_cyc + 1 == e.lat, writing, dirty_load, dirty_in, way_sel} !==
                {1'b1, e.wr, e.dload, e.din, e.way}) begin
                bad++; $display("FAIL %s data: lat=%0d wr=%b dl=%b di=%b way=%b want lat=%0d wr=%b dl=%b di=%b way=%b",
                                name, cyc - e.req_cyc + 1, writing, dirty_load, dirty_in, way_sel,
                                e.lat, e.wr, e.dload, e.din, e.way);
            end
        end
        tick();
        mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0;
        total++;
        if (pw_rise != (wb ? 1 : 0) || pr_rise != 1) begin
            bad++; $display("FAIL %s pmem_count: writes=%0d reads=%0d want %0d/1", name, pw_rise, pr_rise, wb ? 1 : 0);
        end
    endtask

    task automatic test_cold_read();
        run_miss(3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 0, 3, 1'b0, "cold_read");
        total++;
        if ({dut.u_lru.rank_q[3][1], dut.u_lru.rank_q[3][0]} !== 2'b10) begin
            bad++; $display("FAIL cold_read rank: got %b want 10", {dut.u_lru.rank_q[3][1], dut.u_lru.rank_q[3][0]});
        end
    endtask

    task automatic test_write_hit();
        do_hit(3'd5, 1'b1, 1'b0, 1'b1, "write_hit");
        total++;
        if ({dut.u_lru.rank_q[5][1], dut.u_lru.rank_q[5][0]} !== 2'b01) begin
            bad++; $display("FAIL write_hit rank: got %b want 01", {dut.u_lru.rank_q[5][1], dut.u_lru.rank_q[5][0]});
        end
    endtask

    task automatic test_dirty_writeback();
        do_hit(3'd2, 1'b1, 1'b1, 1'b0, "wb_prime");
        total++;
        if ({dut.u_lru.rank_q[2][1], dut.u_lru.rank_q[2][0]} !== 2'b01) begin
            bad++; $display("FAIL wb_prime rank: got %b want 01", {dut.u_lru.rank_q[2][1], dut.u_lru.rank_q[2][0]});
        end
        run_miss(3'd2, 2'b11, 2'b01, 1'b0, 1'b1, 4, 2, 1'b0, "dirty_wb");
        total++;
        if ({dut.u_lru.rank_q[2][1], dut.u_lru.rank_q[2][0]} !== 2'b10) begin
            bad++; $display("FAIL dirty_wb rank: got %b want 10", {dut.u_lru.rank_q[2][1], dut.u_lru.rank_q[2][0]});
        end
    endtask

    task automatic test_invalid_first();
        // Way 1 is LRU in set 2 here, but invalid way 0 must be chosen; its stale dirty bit is ignored.
        run_miss(3'd2, 2'b10, 2'b01, 1'b0, 1'b0, 0, 1, 1'b0, "invalid_first");
    endtask

    task automatic test_clean_victim();
        run_miss(3'd6, 2'b11, 2'b01, 1'b1, 1'b0, 0, 2, 1'b1, "clean_victim");
        total++;
        if ({dut.u_lru.rank_q[6][1], dut.u_lru.rank_q[6][0]} !== 2'b01) begin
            bad++; $display("FAIL clean_victim rank: got %b want 01", {dut.u_lru.rank_q[6][1], dut.u_lru.rank_q[6][0]});
        end
    endtask

    task automatic test_both_req();
        do_hit(3'd7, 1'b1, 1'b1, 1'b1, "both_req");
        total++;
        if ({dut.u_lru.rank_q[7][1], dut.u_lru.rank_q[7][0]} !== 2'b01) begin
            bad++; $display("FAIL both_req rank: got %b want 01", {dut.u_lru.rank_q[7][1], dut.u_lru.rank_q[7][0]});
        end
    endtask

    task automatic test_back_to_back();
        do_hit(3'd5, 1'b0, 1'b1, 1'b0, "b2b_first");
        total++;
        if ({dut.u_lru.rank_q[5][1], dut.u_lru.rank_q[5][0]} !== 2'b10) begin
            bad++; $display("FAIL b2b_first rank: got %b want 10", {dut.u_lru.rank_q[5][1], dut.u_lru.rank_q[5][0]});
        end
        do_hit(3'd5, 1'b1, 1'b1, 1'b0, "b2b_second");
        total++;
        if ({dut.u_lru.rank_q[5][1], dut.u_lru.rank_q[5][0]} !== 2'b01) begin
            bad++; $display("FAIL b2b_second rank: got %b want 01", {dut.u_lru.rank_q[5][1], dut.u_lru.rank_q[5][0]});
        end
    endtask

    task automatic test_reset_mid_fill();
        mem_read = 1'b1; mem_write = 1'b0; set_index = 3'd1; hit = 1'b0;
        valid_vec = 2'b00; dirty_vec = 2'b00; pmem_resp = 1'b0;
        tick();
        tick();
        @(negedge clk);
        total++;
        if (pmem_read !== 1'b1) begin
            bad++; $display("FAIL rst_fill pre: pmem_read=%b want 1", pmem_read);
        end
        tick();
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (outs() !== IDLE_OUTS) begin
            bad++; $display("FAIL rst_fill immediate: got %b want %b", outs(), IDLE_OUTS);
        end
        for (int s = 0; s < NS; s++) begin
            total++;
            if ({dut.u_lru.rank_q[s][1], dut.u_lru.rank_q[s][0]} !== 2'b10) begin
                bad++; $display("FAIL rst_fill rank set %0d: got %b want 10", s,
                                {dut.u_lru.rank_q[s][1], dut.u_lru.rank_q[s][0]});
            end
        end
        tick();
        rst = 1'b1; mem_read = 1'b0; pmem_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (outs() !== IDLE_OUTS) begin
                bad++; $display("FAIL rst_fill spurious[%0d]: got %b want %b", i, outs(), IDLE_OUTS);
            end
            tick();
            pmem_resp = 1'b0;
        end
        do_hit(3'd1, 1'b0, 1'b1, 1'b0, "after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish within budget");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; cyc = 0;
        test_reset();
        test_cold_read();
        test_write_hit();
        test_dirty_writeback();
        test_invalid_first();
        test_clean_victim();
        test_both_req();
        test_back_to_back();
        test_reset_mid_fill();
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: %0d left want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
